idct_prescale_framer: RTL and testbench
=======================================

# idct_prescale_framer

Input-side scaling and framing stage for the inverse-DCT path: takes 24-bit frequency-domain samples from the upstream block, multiplies each by an N-dependent normalisation gain, rounds into the wider FFT input width and regenerates clean sop/eop framing from the frame length latched at sop. It sits directly in front of the FFT core. It is the input-side counterpart of the DCT post-FFT output scaler, which maps wide FFT results down to 24 bits.

## Interface
Parameters:
- wDataIn, 24, input sample width (signed)
- wDataOut, 28, output sample width fed to FFT core (signed)
- wGain, 18, gain coefficient width (signed, Q1.16)

Ports:
- clk  in  1  clock; the block has one clock, and all logic runs on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sink_valid  in  1  input sample valid
- sink_ready  out  1  block can accept input
- sink_sop  in  1  first sample of input frame
- sink_eop  in  1  last sample of input frame (checked only, never forwarded)
- sink_real, sink_imag  in  wDataIn  input sample
- fftpts_in  in  12  frame length N, sampled on accepted sop
- source_valid  out  1  output valid
- source_ready  in  1  downstream can accept
- source_sop, source_eop  out  1  regenerated framing
- source_real, source_imag  out  wDataOut  scaled sample
- fftpts_out  out  12  latched N, aligned with output samples
- frame_err  out  1  one-cycle pulse on framing violation

## Operation
- A sample is accepted when sink_valid & sink_ready.
- Pipeline enable en = !source_valid | source_ready, and sink_ready = en.
- Frame controller states:
  - IDLE: an accepted sample with sink_sop latches fftpts_in into pts_q, selects the gain, clears cnt, marks the output sample sop, and moves to RUN, or stays in IDLE when pts_q = 1.
  - IDLE: an accepted sample without sop is consumed and dropped (nothing is output) and frame_err pulses.
  - RUN: each accepted sample increments cnt. The sample with cnt == pts_q-1 is marked eop and the state returns to IDLE.
- Gain table (pts → gain): 2048→65536, 1024→46341, 512→32768, 256→23170, 128→16384, 64→11585, 32→8192.
- Unsupported N: gain 65536, pts_q forced to 2048, and frame_err pulses.
- Arithmetic for each component:
  - p = x * gain, 42-bit signed
  - y = (p + 2^11) >>> 12, which is round half up
  - Saturate y to the signed wDataOut range and assert overflow internally. Saturation is unreachable with the table above, but it is kept for table edits.
  - This gives output = 16 · gain/65536 · input.
- Errors checked in RUN (frame_err pulses; data is still processed normally):
  - sink_sop on a sample with cnt ≠ 0: the sop is ignored and the sample is treated as data
  - sink_eop on a sample with cnt ≠ pts_q-1
  - missing sink_eop on the cnt == pts_q-1 sample
- The error checks are active only when the macro in Configuration is defined.

## Timing
- Reset values: source_valid 0, source_sop 0, source_eop 0, source_real 0, source_imag 0, fftpts_out 0, frame_err 0; state IDLE, cnt 0, pts_q 2048.
- sink_ready is combinational from source_ready and source_valid.
- Latency from accepted sample to source_valid is 2 cycles when unstalled. Stage 1 registers the input, gain and flags; stage 2 registers the rounded product.
- The pipeline is stall-all. When en = 0, both stages hold and outputs stay stable, following valid/ready hold rules.
- A bubble (sink_valid = 0 while en = 1) propagates as valid = 0 and does not advance cnt.
- frame_err is registered and appears 1 cycle after the offending sample is accepted, independent of stalls.
- Back-to-back frames: a sop accepted in the cycle after the eop sample is legal, with no gap required.
- Reset asserted mid-frame clears the pipeline and counter immediately. The next frame must begin with sop.

## Configuration
- Macro: IDCT_PRESCALE_FRAMECHK_EN.
- Defined: all RUN-state error checks and the unsupported-N flag drive frame_err.
- Undefined: frame_err is tied to 0 and sink_eop is unused. Dropping of non-sop samples in IDLE and the unsupported-N fallback still happen, silently.

## Structure
- Shared package idct_pkg holds:
  - width constants (24/28/18, shift 12)
  - the gain lookup function gain_of(pts) and the supported-pts check
  - the state enum {IDLE, RUN}
- Sub-module idct_prescale_frame_ctrl holds the state machine, cnt, pts_q, sop/eop marking and error detection. The top level holds the multiply/round/saturate datapath and the pipeline registers.

## Test plan
- N=32 frame, input real = 1000, source_ready = 1 → 32 outputs.
  - real = 2000 (16·8192/65536·1000), 2 cycles after each input.
  - sop on the first output, eop on the 32nd, fftpts_out = 32.
- N=1024, input real = -8388608, imag = 8388607.
  - Outputs: real = -94906368 and imag = 94906357, computed as round(x·46341/4096).
  - Rounding check: input 1 with N=2048 gives 16, and input 1 with N=1024 gives 11.
- Stall: hold source_ready = 0 for 5 cycles mid-frame.
  - sink_ready = 0 whenever source_valid = 1.
  - Outputs are stable while stalled, no sample is lost, and eop still lands on sample N.
- Framing errors with the macro defined:
  - a sample without sop in IDLE → dropped and frame_err pulses
  - sink_eop at sample 10 of a 32-sample frame → frame_err pulses and eop is still output at sample 32
  - fftpts_in = 100 → frame_err pulses and the frame runs for 2048 samples
- Reset: assert rst_n low asynchronously mid-frame → all outputs become 0 immediately. After release, a new sop frame is output correctly from its first sample.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared constants, gain lookup and frame-controller state for the IDCT input
// prescaler. Optional framing checks are enabled by IDCT_PRESCALE_FRAMECHK_EN.
package idct_pkg;
  localparam int W_IN      = 24;
  localparam int W_OUT     = 28;
  localparam int W_GAIN    = 18;
  localparam int W_PTS     = 12;
  localparam int RND_SHIFT = 12;

  localparam logic [W_PTS-1:0] PTS_MAX = 12'd2048;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  // Frame lengths with a normalisation gain in the table
  function automatic logic pts_ok(input logic [W_PTS-1:0] pts);
    case (pts)
      12'd2048, 12'd1024, 12'd512, 12'd256,
      12'd128, 12'd64, 12'd32: pts_ok = 1'b1;
      default:                 pts_ok = 1'b0;
    endcase
  endfunction

  // Q1.16 gain, 1/sqrt(2) per halving of N; unknown N falls back to unity
  function automatic logic signed [W_GAIN-1:0] gain_of(input logic [W_PTS-1:0] pts);
    case (pts)
      12'd2048: gain_of = 18'sd65536;
      12'd1024: gain_of = 18'sd46341;
      12'd512:  gain_of = 18'sd32768;
      12'd256:  gain_of = 18'sd23170;
      12'd128:  gain_of = 18'sd16384;
      12'd64:   gain_of = 18'sd11585;
      12'd32:   gain_of = 18'sd8192;
      default:  gain_of = 18'sd65536;
    endcase
  endfunction
endpackage

// File: rtl/idct_prescale_frame_ctrl.sv
// Frame controller: tracks position in the frame, latches N at sop, marks
// output sop/eop, selects the gain and flags framing violations when
// IDCT_PRESCALE_FRAMECHK_EN is defined.
module idct_prescale_frame_ctrl
  import idct_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     acc_i,
  input  logic                     sop_i,
  input  logic                     eop_i,
  input  logic [W_PTS-1:0]         pts_i,
  output logic                     keep_o,
  output logic                     sop_o,
  output logic                     eop_o,
  output logic [W_PTS-1:0]         pts_o,
  output logic signed [W_GAIN-1:0] gain_o,
  output logic                     err_o
);
  state_e           state_q, state_d;
  logic [W_PTS-1:0] cnt_q, cnt_d, pts_q, pts_d, pts_new;
  logic             start, last, err_d;

  assign pts_new = pts_ok(pts_i) ? pts_i : PTS_MAX;
  assign start   = (state_q == IDLE) && sop_i;
  assign last    = start ? (pts_new == 12'd1) : (cnt_q == pts_q - 12'd1);

  // State, counter, latched N and the registered error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pts_q   <= PTS_MAX;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pts_q   <= pts_d;
      err_o   <= err_d;
    end
  end

  // Next state: only accepted samples move the frame position
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pts_d   = pts_q;
    if (acc_i) begin
      case (state_q)
        IDLE: if (sop_i) begin
          pts_d = pts_new;
          cnt_d = last ? '0 : 12'd1;
          if (!last) state_d = RUN;
        end
        RUN: begin
          cnt_d = last ? '0 : cnt_q + 12'd1;
          if (last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: framing marks, gain for this sample and error detection
  always_comb begin
    keep_o = acc_i && ((state_q == RUN) || sop_i);
    sop_o  = start;
    eop_o  = last;
    pts_o  = start ? pts_new : pts_q;
    gain_o = gain_of(pts_o);
    err_d  = 1'b0;
`ifdef IDCT_PRESCALE_FRAMECHK_EN
    if (acc_i) begin
      if (state_q == IDLE) err_d = !sop_i || !pts_ok(pts_i);
      else                 err_d = sop_i || (eop_i != last);
    end
`endif
  end

`ifndef IDCT_PRESCALE_FRAMECHK_EN
  logic unused_eop;
  assign unused_eop = eop_i;
`endif
endmodule

// File: rtl/idct_prescale_framer.sv
// IDCT input prescaler: two-stage stall-all pipeline that scales each sample
// by the N-dependent gain (x*g/4096, round half up, saturate) and emits
// regenerated sop/eop. Framing checks are under IDCT_PRESCALE_FRAMECHK_EN.
module idct_prescale_framer
  import idct_pkg::*;
#(
  parameter int wDataIn  = W_IN,
  parameter int wDataOut = W_OUT,
  parameter int wGain    = W_GAIN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sink_valid,
  output logic                       sink_ready,
  input  logic                       sink_sop,
  input  logic                       sink_eop,
  input  logic signed [wDataIn-1:0]  sink_real,
  input  logic signed [wDataIn-1:0]  sink_imag,
  input  logic [W_PTS-1:0]           fftpts_in,
  output logic                       source_valid,
  input  logic                       source_ready,
  output logic                       source_sop,
  output logic                       source_eop,
  output logic signed [wDataOut-1:0] source_real,
  output logic signed [wDataOut-1:0] source_imag,
  output logic [W_PTS-1:0]           fftpts_out,
  output logic                       frame_err
);
  localparam int WP = wDataIn + wGain;
  localparam logic signed [WP-1:0] RND  = WP'(1) << (RND_SHIFT - 1);
  localparam logic signed [WP-1:0] YMAX = {{(WP-wDataOut+1){1'b0}}, {(wDataOut-1){1'b1}}};
  localparam logic signed [WP-1:0] YMIN = ~YMAX;

  logic                       en, acc;
  logic                       c_keep, c_sop, c_eop;
  logic [W_PTS-1:0]           c_pts;
  logic signed [W_GAIN-1:0]   c_gain;
  logic                       v1_q, sop1_q, eop1_q;
  logic signed [wDataIn-1:0]  re1_q, im1_q;
  logic signed [wGain-1:0]    gain1_q;
  logic [W_PTS-1:0]           pts1_q;
  logic signed [WP-1:0]       yr, yi;
  logic                       ovf;

  assign en         = !source_valid || source_ready;
  assign sink_ready = en;
  assign acc        = sink_valid && en;

  function automatic logic signed [WP-1:0] scale(input logic signed [wDataIn-1:0] x,
                                                 input logic signed [wGain-1:0]   g);
    logic signed [WP-1:0] p;
    p = WP'(x) * WP'(g);
    return (p + RND) >>> RND_SHIFT;
  endfunction

  function automatic logic signed [wDataOut-1:0] sat(input logic signed [WP-1:0] y);
    if (y > YMAX)      return YMAX[wDataOut-1:0];
    else if (y < YMIN) return YMIN[wDataOut-1:0];
    else               return y[wDataOut-1:0];
  endfunction

  idct_prescale_frame_ctrl u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .acc_i  (acc),
    .sop_i  (sink_sop),
    .eop_i  (sink_eop),
    .pts_i  (fftpts_in),
    .keep_o (c_keep),
    .sop_o  (c_sop),
    .eop_o  (c_eop),
    .pts_o  (c_pts),
    .gain_o (c_gain),
    .err_o  (frame_err)
  );

  assign yr  = scale(re1_q, gain1_q);
  assign yi  = scale(im1_q, gain1_q);
  assign ovf = (yr > YMAX) || (yr < YMIN) || (yi > YMAX) || (yi < YMIN);

  // Saturation only matters if the gain table is edited upward
  assert property (@(posedge clk) disable iff (!rst_n) !(v1_q && ovf));

  // Stage 1 captures sample, gain and flags; stage 2 the rounded product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      sop1_q       <= 1'b0;
      eop1_q       <= 1'b0;
      re1_q        <= '0;
      im1_q        <= '0;
      gain1_q      <= '0;
      pts1_q       <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_real  <= '0;
      source_imag  <= '0;
      fftpts_out   <= '0;
    end else if (en) begin
      v1_q         <= c_keep;
      sop1_q       <= c_keep && c_sop;
      eop1_q       <= c_keep && c_eop;
      re1_q        <= sink_real;
      im1_q        <= sink_imag;
      gain1_q      <= wGain'(c_gain);
      pts1_q       <= c_pts;
      source_valid <= v1_q;
      source_sop   <= v1_q && sop1_q;
      source_eop   <= v1_q && eop1_q;
      source_real  <= sat(yr);
      source_imag  <= sat(yi);
      fftpts_out   <= pts1_q;
    end
  end
endmodule

// File: tb/tb_idct_prescale_framer.sv
// Self-checking bench for idct_prescale_framer: table-driven frames plus
// hand-written stall, framing-error and reset sequences, checked through an
// output scoreboard. Error expectations follow IDCT_PRESCALE_FRAMECHK_EN.
module tb_idct_prescale_framer;
  logic               clk = 1'b0, rst_n = 1'b0;
  logic               sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
  logic               source_ready = 1'b1;
  logic               sink_ready;
  logic signed [23:0] sink_real = '0, sink_imag = '0;
  logic [11:0]        fftpts_in = '0;
  logic               source_valid, source_sop, source_eop, frame_err;
  logic signed [27:0] source_real, source_imag;
  logic [11:0]        fftpts_out;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;

`ifdef IDCT_PRESCALE_FRAMECHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {bit sop; bit eop; int re; int im; int pts; int cyc; bit lat;} exp_t;
  typedef struct {int pts; int re; int im; int exp_re; int exp_im;} vec_t;

  exp_t sb[$];
  bit   in_frame = 1'b0;
  int   idx = 0, n_cur = 2048, g_cur = 65536;
  bit   lat_on = 1'b1;

  idct_prescale_framer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_real    (sink_real),
    .sink_imag    (sink_imag),
    .fftpts_in    (fftpts_in),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .fftpts_out   (fftpts_out),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit tb_pts_ok(input int p);
    return p == 2048 || p == 1024 || p == 512 || p == 256 || p == 128 || p == 64 || p == 32;
  endfunction

  function automatic int tb_gain(input int p);
    case (p)
      1024:    return 46341;
      512:     return 32768;
      256:     return 23170;
      128:     return 16384;
      64:      return 11585;
      32:      return 8192;
      default: return 65536;
    endcase
  endfunction

  // Reference: x*g/4096 rounded half up, via real arithmetic
  function automatic int ref_scale(input int x, input int g);
    real r;
    r = real'(x) * real'(g) / 4096.0;
    return int'($floor(r + 0.5));
  endfunction

  // Present one sample, wait for acceptance, update the frame model,
  // push the expected output and check the frame_err pulse one cycle later.
  task automatic send(input bit sop, input bit eop, input int pts, input int re, input int im,
                      input bit use_tab, input int tre, input int tim);
    bit   acc, err_e, out_e;
    int   k;
    exp_t e;
    sink_valid = 1'b1; sink_sop = sop; sink_eop = eop;
    fftpts_in = 12'(pts); sink_real = 24'(re); sink_imag = 24'(im);
    acc = 1'b0; k = 0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = sink_ready;
      k = cyc;
      @(posedge clk);
      #1;
    end
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    if (!acc) begin
      check("accept_timeout", 0, 1);
      return;
    end
    err_e = 1'b0; out_e = 1'b0;
    e.sop = 1'b0; e.eop = 1'b0;
    if (!in_frame) begin
      if (sop) begin
        err_e = !tb_pts_ok(pts);
        n_cur = tb_pts_ok(pts) ? pts : 2048;
        g_cur = tb_gain(n_cur);
        e.sop = 1'b1; e.eop = (n_cur == 1);
        idx = 1; in_frame = (n_cur != 1); out_e = 1'b1;
      end else begin
        err_e = 1'b1;
      end
    end else begin
      e.eop = (idx == n_cur - 1);
      err_e = sop || (eop != e.eop);
      out_e = 1'b1;
      idx++;
      if (e.eop) in_frame = 1'b0;
    end
    e.re  = use_tab ? tre : ref_scale(re, g_cur);
    e.im  = use_tab ? tim : ref_scale(im, g_cur);
    e.pts = n_cur; e.cyc = k; e.lat = lat_on;
    if (out_e) sb.push_back(e);
    check("frame_err", frame_err, CHK & err_e);
  endtask

  task automatic drain();
    for (int t = 0; t < 5000 && sb.size() > 0; t++) @(negedge clk);
    check("drain_pending", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Output monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && source_valid && !source_ready) check("sink_ready_stalled", sink_ready, 0);
    if (rst_n && source_valid && source_ready) begin
      if (sb.size() == 0) check("unexpected_output", 1, 0);
      else begin
        e = sb.pop_front();
        check("real", source_real, e.re);
        check("imag", source_imag, e.im);
        check("sop", source_sop, e.sop);
        check("eop", source_eop, e.eop);
        check("fftpts_out", fftpts_out, e.pts);
        if (e.lat) check("latency", cyc - e.cyc, 2);
      end
    end
  end

  initial begin
    vec_t tab[8];
    logic signed [27:0] s_re;
    logic s_v, s_eop;
    tab = '{'{32,   1000,     -1000,   2000,      -2000},
            '{1024, -8388608, 8388607, -94906368, 94906357},
            '{2048, 1,        -1,      16,        -16},
            '{1024, 1,        -1,      11,        -11},
            '{64,   4096,     0,       11585,     0},
            '{128,  -3,       5,       -12,       20},
            '{256,  100,      7,       566,       40},
            '{512,  -2048,    3,       -16384,    24}};

    // Reset state
    #3;
    check("rst_valid", source_valid, 0);
    check("rst_sop", source_sop, 0);
    check("rst_eop", source_eop, 0);
    check("rst_real", source_real, 0);
    check("rst_imag", source_imag, 0);
    check("rst_pts", fftpts_out, 0);
    check("rst_err", frame_err, 0);
    check("rst_sink_ready", sink_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: one constant-data frame per row
    foreach (tab[i]) begin
      for (int j = 0; j < tab[i].pts; j++)
        send(j == 0, j == tab[i].pts - 1, tab[i].pts, tab[i].re, tab[i].im,
             1'b1, tab[i].exp_re, tab[i].exp_im);
      drain();
    end

    // Stall for 5 cycles mid-frame; outputs must hold
    lat_on = 1'b0;
    for (int j = 0; j < 32; j++) begin
      if (j == 16) begin
        source_ready = 1'b0;
        @(negedge clk);
        s_v = source_valid; s_re = source_real; s_eop = source_eop;
        check("stall_valid", s_v, 1);
        repeat (4) begin
          @(negedge clk);
          check("stall_hold_valid", source_valid, s_v);
          check("stall_hold_real", source_real, s_re);
          check("stall_hold_eop", source_eop, s_eop);
        end
        @(posedge clk); #1 source_ready = 1'b1;
      end
      send(j == 0, j == 31, 32, j * 1000 - 7, -j, 1'b0, 0, 0);
    end
    drain();
    lat_on = 1'b1;

    // Stray sample in IDLE is dropped
    send(1'b0, 1'b0, 32, 55, 55, 1'b0, 0, 0);
    drain();

    // Early eop at sample 10, bubbles mid-frame, eop still lands on 32
    for (int j = 0; j < 32; j++) begin
      send(j == 0, j == 9 || j == 31, 32, 300 + j, -300 - j, 1'b0, 0, 0);
      if (j == 5) begin repeat (3) @(posedge clk); #1; end
    end
    drain();

    // Mid-frame sop treated as data, missing eop, then a back-to-back frame
    for (int j = 0; j < 32; j++) send(j == 0 || j == 4, 1'b0, 32, j, 2 * j, 1'b0, 0, 0);
    for (int j = 0; j < 64; j++) send(j == 0, j == 63, 64, -j, j, 1'b0, 0, 0);
    drain();

    // Unsupported N falls back to 2048
    for (int j = 0; j < 2048; j++) send(j == 0, j == 2047, 100, 7 - j, j, 1'b0, 0, 0);
    drain();

    // Asynchronous reset mid-frame
    for (int j = 0; j < 20; j++) send(j == 0, 1'b0, 64, 900 + j, j, 1'b0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", source_valid, 0);
    check("arst_sop", source_sop, 0);
    check("arst_eop", source_eop, 0);
    check("arst_real", source_real, 0);
    check("arst_imag", source_imag, 0);
    check("arst_pts", fftpts_out, 0);
    check("arst_err", frame_err, 0);
    sb.delete();
    in_frame = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    send(1'b0, 1'b0, 32, 11, 11, 1'b0, 0, 0);
    for (int j = 0; j < 32; j++) send(j == 0, j == 31, 32, j + 1, -j - 1, 1'b0, 0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
